card_dealer: RTL



---
 rtl/card_dealer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/card_dealer.sv
// card_dealer
//   Card source for the bell game. Deals a pseudo-random card alternately
//   into slot A (c1/n1) and slot B (c2/n2) on a fixed period. It also runs a
//   decaying award value (count) that restarts at every deal. When a round
//   resolves (rising edge of finish), both slots are cleared. Dealing resumes
//   once finish drops.
//
//   Ports
//     clk         clock
//     rst         asynchronous active-high reset
//     start       level; leaves IDLE and begins dealing
//     finish      round resolved; its rising edge clears the table
//     c1, n1      slot A colour (0..3) / number (1..5, 0 = empty)
//     c2, n2      slot B colour (0..3) / number (1..5, 0 = empty)
//     count       current award value
//     card_valid  high while a dealt card is on show
//     turn        slot the next deal goes to (0 = A, 1 = B)
//     game_over   deck exhausted (deck-limit build only, else 0)
//
//   Build option
//     CARD_DEALER_DECK_LIMIT_EN : stop after DECK_SIZE deals and park in DONE.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | after reset, slots empty, count 0, waiting for start
//   DEAL  | one cycle: write card into slot `turn`, reload count and timer
//   SHOW  | card up; period timer and count divider run
//   CLEAR | round resolved, slots zeroed, waiting for finish to drop
//   DONE  | deck exhausted, slots held (deck-limit build only)

module card_dealer #(
  parameter int          DEAL_PERIOD = 1000,
  parameter logic [7:0]  COUNT_INIT  = 8'd100,
  parameter int          COUNT_DIV   = 10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          DECK_SIZE   = 56
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       finish,
  output logic [1:0] c1,
  output logic [2:0] n1,
  output logic [1:0] c2,
  output logic [2:0] n2,
  output logic [7:0] count,
  output logic       card_valid,
  output logic       turn,
  output logic       game_over
);

  localparam int TW   = $clog2(DEAL_PERIOD);
  localparam int DIVW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [TW-1:0]   TMR_LOAD = TW'(DEAL_PERIOD - 1);
  localparam logic [DIVW-1:0] DIV_LOAD = DIVW'(COUNT_DIV - 1);
  localparam logic [15:0]     TAPS     = 16'hB400;

  if (DEAL_PERIOD < 2 || COUNT_DIV < 1 || LFSR_SEED == 16'h0000 || DECK_SIZE < 1) begin : g_bad_params
    $error("card_dealer: illegal parameter set");
  end

`ifdef CARD_DEALER_DECK_LIMIT_EN
  typedef enum logic [2:0] {IDLE, DEAL, SHOW, CLEAR, DONE} state_t;
  localparam int DCW = $clog2(DECK_SIZE + 1);
  logic [DCW-1:0] deal_cnt;
  logic           last_deal;
  assign last_deal = (deal_cnt == DCW'(DECK_SIZE - 1));
`else
  typedef enum logic [1:0] {IDLE, DEAL, SHOW, CLEAR} state_t;
  assign game_over = 1'b0;
`endif

  state_t          state;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_next;
  logic [TW-1:0]   timer;
  logic [DIVW-1:0] div_cnt;
  logic            finish_q;
  logic            finish_edge;
  logic [2:0]      raw;
  logic [1:0]      new_c;
  logic [2:0]      new_n;

  // Right-shifting Galois LFSR; taps folded in when bit 0 falls out.
  assign lfsr_next   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
  assign finish_edge = finish & ~finish_q;

  // Fold the 3-bit raw field onto 1..5 so an empty slot (0) never appears.
  always_comb begin
    raw   = lfsr[4:2];
    new_c = lfsr[1:0];
    new_n = (raw < 3'd5) ? raw + 3'd1 : raw - 3'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      timer      <= '0;
      div_cnt    <= '0;
      finish_q   <= 1'b0;
      c1         <= '0;
      n1         <= '0;
      c2         <= '0;
      n2         <= '0;
      count      <= '0;
      card_valid <= 1'b0;
      turn       <= 1'b0;
`ifdef CARD_DEALER_DECK_LIMIT_EN
      deal_cnt   <= '0;
      game_over  <= 1'b0;
`endif
    end else begin
      lfsr     <= lfsr_next;
      finish_q <= finish;
      case (state)
        IDLE: begin
          card_valid <= 1'b0;
          if (start) state <= DEAL;
        end

        DEAL: begin
          // A finish edge aborts the deal entirely: no card, no turn change.
          if (finish_edge) begin
            state      <= CLEAR;
            c1         <= '0;
            n1         <= '0;
            c2         <= '0;
            n2         <= '0;
            card_valid <= 1'b0;
          end else begin
            if (!turn) begin
              c1 <= new_c;
              n1 <= new_n;
            end else begin
              c2 <= new_c;
              n2 <= new_n;
            end
            turn    <= ~turn;
            timer   <= TMR_LOAD;
            div_cnt <= DIV_LOAD;
`ifdef CARD_DEALER_DECK_LIMIT_EN
            deal_cnt <= deal_cnt + DCW'(1);
            if (last_deal) begin
              state      <= DONE;
              count      <= '0;
              card_valid <= 1'b0;
              game_over  <= 1'b1;
            end else begin
              state      <= SHOW;
              count      <= COUNT_INIT;
              card_valid <= 1'b1;
            end
`else
            state      <= SHOW;
            count      <= COUNT_INIT;
            card_valid <= 1'b1;
`endif
          end
        end

        SHOW: begin
          if (finish_edge) begin
            state      <= CLEAR;
            c1         <= '0;
            n1         <= '0;
            c2         <= '0;
            n2         <= '0;
            card_valid <= 1'b0;
          end else begin
            if (div_cnt == '0) begin
              div_cnt <= DIV_LOAD;
              if (count != 8'd0) count <= count - 8'd1;
            end else begin
              div_cnt <= div_cnt - DIVW'(1);
            end
            if (timer == '0) begin
              state      <= DEAL;
              card_valid <= 1'b0;
            end else begin
              timer <= timer - TW'(1);
            end
          end
        end

        CLEAR: begin
          card_valid <= 1'b0;
          if (!finish) state <= DEAL;
        end

`ifdef CARD_DEALER_DECK_LIMIT_EN
        DONE: begin
          card_valid <= 1'b0;
          count      <= '0;
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
